// File: rtl/comparator_pkg.sv
// Shared width default and named three-way compare result codes.
package comparator_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;

   // Result codes as signed integers; cast to the operand width when used (-1 becomes all-ones).
   localparam int EQUAL   = 0;
   localparam int GREATER = 1;
   localparam int LESS    = -1;

endpackage : comparator_pkg

// File: rtl/comparator_core.sv
// Combinational magnitude comparator producing one-hot eq/gt/lt flags.
module comparator_core
   import comparator_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] num1_i,
   input  logic [WIDTH-1:0] num2_i,
   input  logic             is_signed_i,
   output logic             eq_o,
   output logic             gt_o,
   output logic             lt_o
);

   logic gt_signed;
   logic gt_unsigned;

   always_comb begin
      gt_signed   = $signed(num1_i) > $signed(num2_i);
      gt_unsigned = num1_i > num2_i;
      eq_o        = (num1_i == num2_i);
      gt_o        = is_signed_i ? gt_signed : gt_unsigned;
      // Equality is mode-independent, so less-than is simply "neither".
      lt_o        = !eq_o && !gt_o;
   end

endmodule : comparator_core

// File: rtl/comparator.sv
// Registered three-way comparator: one-cycle latency, result code encoded from the flags.
module comparator
   import comparator_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   logic             eq_d;
   logic             gt_d;
   logic             lt_d;
   logic [WIDTH-1:0] result_d;

   logic [WIDTH-1:0] result_q;
   logic             out_valid_q;
   logic             eq_q;
   logic             gt_q;
   logic             lt_q;

   comparator_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .num1_i      (num1),
      .num2_i      (num2),
      .is_signed_i (is_signed),
      .eq_o        (eq_d),
      .gt_o        (gt_d),
      .lt_o        (lt_d)
   );

   always_comb begin
      result_d = WIDTH'(EQUAL);
      if (gt_d) begin
         result_d = WIDTH'(GREATER);
      end else if (lt_d) begin
         result_d = WIDTH'(LESS);
      end
   end

   // Flags and code update only on accepted operands; they hold while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q    <= WIDTH'(EQUAL);
         out_valid_q <= 1'b0;
         eq_q        <= 1'b1;
         gt_q        <= 1'b0;
         lt_q        <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            result_q <= result_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
         end
      end
   end

   assign result    = result_q;
   assign out_valid = out_valid_q;
   assign eq        = eq_q;
   assign gt        = gt_q;
   assign lt        = lt_q;

endmodule : comparator

// File: tb/tb_comparator.sv
// Directed plus randomized checks of comparator against an integer-arithmetic reference model.
module tb_comparator;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         is_signed = 1'b0;
   logic [W-1:0] num1 = '0;
   logic [W-1:0] num2 = '0;
   logic [W-1:0] result;
   logic         out_valid;
   logic         eq;
   logic         gt;
   logic         lt;

   int checks = 0;
   int passed = 0;

   // Model-side expected state of the registered outputs.
   logic [W-1:0] m_result;
   logic         m_valid;
   logic         m_eq;
   logic         m_gt;
   logic         m_lt;

   comparator #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .is_signed (is_signed),
      .num1      (num1),
      .num2      (num2),
      .result    (result),
      .out_valid (out_valid),
      .eq        (eq),
      .gt        (gt),
      .lt        (lt)
   );

   always #5 clk = ~clk;

   // Interpret operands as integers in the chosen mode and compare numerically.
   function automatic int cmp3(logic [W-1:0] a, logic [W-1:0] b, bit s);
      longint x;
      longint y;
      x = s ? longint'($signed(a)) : longint'({1'b0, a});
      y = s ? longint'($signed(b)) : longint'({1'b0, b});
      if (x > y) return 1;
      if (x < y) return -1;
      return 0;
   endfunction

   task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic check_all(string tag);
      chk({tag, ".out_valid"}, W'(out_valid), W'(m_valid));
      chk({tag, ".result"},    result,         m_result);
      chk({tag, ".eq"},        W'(eq),         W'(m_eq));
      chk({tag, ".gt"},        W'(gt),         W'(m_gt));
      chk({tag, ".lt"},        W'(lt),         W'(m_lt));
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic step(string tag, bit r, bit v, bit s, logic [W-1:0] a, logic [W-1:0] b);
      int c;
      @(negedge clk);
      rst       = r;
      in_valid  = v;
      is_signed = s;
      num1      = a;
      num2      = b;
      @(posedge clk);
      if (r) begin
         m_result = '0;
         m_valid  = 1'b0;
         m_eq     = 1'b1;
         m_gt     = 1'b0;
         m_lt     = 1'b0;
      end else begin
         m_valid = v;
         if (v) begin
            c        = cmp3(a, b, s);
            m_result = W'(c);
            m_eq     = (c == 0);
            m_gt     = (c > 0);
            m_lt     = (c < 0);
         end
      end
      #1;
      check_all(tag);
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] corner [6];
      corner[0] = 16'h0000;
      corner[1] = 16'hFFFF;
      corner[2] = 16'h8000;
      corner[3] = 16'h7FFF;
      corner[4] = 16'h0001;
      corner[5] = 16'h8001;
      if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
      return W'($urandom);
   endfunction

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;

      m_result = 'x;
      m_valid  = 1'bx;
      m_eq     = 1'bx;
      m_gt     = 1'bx;
      m_lt     = 1'bx;

      step("reset0", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step("reset1", 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0001);

      step("uns_eq",   1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001);
      step("uns_gt",   1'b0, 1'b1, 1'b0, 16'h0004, 16'h0001);
      step("uns_lt",   1'b0, 1'b1, 1'b0, 16'h0001, 16'h0004);
      step("sgn_neg",  1'b0, 1'b1, 1'b1, 16'h8000, 16'h0001);
      step("uns_big",  1'b0, 1'b1, 1'b0, 16'h8000, 16'h0001);
      step("sgn_eq",   1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
      step("sgn_edge", 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h8000);

      // Three back-to-back vectors, then idle: result must hold with out_valid low.
      step("stream0", 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0020);
      step("stream1", 1'b0, 1'b1, 1'b0, 16'h0030, 16'h0030);
      step("stream2", 1'b0, 1'b1, 1'b1, 16'h0001, 16'hFFFF);
      step("idle0",   1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999);
      step("idle1",   1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000);

      // Reset wins over a simultaneous valid operand pair.
      step("lt_pre",    1'b0, 1'b1, 1'b0, 16'h0001, 16'h0002);
      step("rst_valid", 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0001);
      step("post_idle", 1'b0, 1'b0, 1'b0, 16'h0009, 16'h0001);
      step("post_first",1'b0, 1'b1, 1'b0, 16'h0009, 16'h0001);

      for (int i = 0; i < 300; i++) begin
         a = pick_operand();
         b = ($urandom_range(4) == 0) ? a : pick_operand();
         step("rand", ($urandom_range(40) == 0), ($urandom_range(4) != 0),
              1'($urandom_range(1)), a, b);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_comparator
